snake_ram_scheduler: RTL and testbench

//  Sole owner of the snake_ram ports (1-bit x FB_DEPTH frame-occupancy map, 1-cycle read latency).

---
 rtl/snake_ram_scheduler_pkg.sv | 25 ++
 rtl/snake_ram_scheduler_arbiter.sv | 50 +++++
 rtl/snake_ram_scheduler.sv | 154 +++++++++++++++
 tb/tb_snake_ram_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_ram_scheduler_pkg.sv
// Shared constants for the snake_ram scheduler: frame geometry, address width,
// FSM encoding and the shift-add row base helper used by the display scan.
package snake_ram_scheduler_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int FB_DEPTH   = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W     = 19;
  localparam int STARVE_MAX = 4;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  // row * h built only from shifted copies of row; with h constant this
  // collapses to a few adders (640 -> row<<9 + row<<7).
  function automatic logic [ADDR_W-1:0] row_base(input logic [9:0] row, input int unsigned h);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      if (h[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/snake_ram_scheduler_arbiter.sv
// Write-port arbiter: head painter has priority over tail eraser unless the
// tail has been passed over STARVE_MAX times in a row. A requester whose ack
// is high this cycle keeps its priority but is not granted again, so a held
// request never produces a double write; that slot simply stays idle.
module snake_wr_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic pixel_clock,
  input  logic reset,
  input  logic enable,
  input  logic head_req,
  input  logic tail_req,
  output logic head_grant,
  output logic tail_grant,
  output logic head_ack,
  output logic tail_ack
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          tail_first;

  // pick the winner on raw requests, then suppress a winner that is still acked
  always_comb begin
    head_grant = 1'b0;
    tail_grant = 1'b0;
    tail_first = tail_req && (!head_req || starve_cnt == STARVE_LIM);
    if (enable) begin
      if (tail_first) tail_grant = !tail_ack;
      else if (head_req) head_grant = !head_ack;
    end
  end

  // registered ack pulses and the count of tail pass-overs
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      head_ack   <= 1'b0;
      tail_ack   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      head_ack <= head_grant;
      tail_ack <= tail_grant;
      if (!tail_req || tail_grant) starve_cnt <= '0;
      else if (head_grant) starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/snake_ram_scheduler.sv
// Sole owner of the snake_ram ports. Sweeps the map to zero after reset or on
// clear_req, arbitrates head/tail writes, and shares the read port between the
// display scan (active video) and a single outstanding collision probe.
module snake_ram_scheduler #(
  parameter int H_ACTIVE   = snake_ram_scheduler_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = snake_ram_scheduler_pkg::V_ACTIVE,
  parameter int STARVE_MAX = snake_ram_scheduler_pkg::STARVE_MAX
) (
  input  logic                                       pixel_clock,
  input  logic                                       reset,
  input  logic [9:0]                                 pixel_row,
  input  logic [9:0]                                 pixel_column,
  input  logic                                       clear_req,
  output logic                                       clear_busy,
  input  logic                                       head_req,
  input  logic [snake_ram_scheduler_pkg::ADDR_W-1:0] head_addr,
  input  logic                                       head_data,
  output logic                                       head_ack,
  input  logic                                       tail_req,
  input  logic [snake_ram_scheduler_pkg::ADDR_W-1:0] tail_addr,
  output logic                                       tail_ack,
  input  logic                                       probe_req,
  input  logic [snake_ram_scheduler_pkg::ADDR_W-1:0] probe_addr,
  output logic                                       probe_ack,
  output logic                                       probe_valid,
  output logic                                       probe_data,
  output logic [snake_ram_scheduler_pkg::ADDR_W-1:0] ram_wraddress,
  output logic                                       ram_data,
  output logic                                       ram_wren,
  output logic [snake_ram_scheduler_pkg::ADDR_W-1:0] ram_rdaddress,
  input  logic                                       ram_q,
  output logic                                       pix_data
);

  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;

  import snake_ram_scheduler_pkg::*;

  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [9:0]        H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM   = 10'(V_ACTIVE);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] sweep_ptr;
  logic [ADDR_W-1:0] scan_addr;
  logic              active_now;
  logic              arb_enable;
  logic              head_grant;
  logic              tail_grant;
  logic              probe_grant;
  logic              probe_busy;
  logic              active_d1, active_d2;
  logic              tag_d1, tag_d2;
  logic              range_d1, range_d2;

  // clear_req inside a sweep restarts it from address 0 this very cycle
  always_comb begin
    sweep_ptr   = clear_req ? '0 : clr_ptr;
    active_now  = (pixel_row < V_LIM) && (pixel_column < H_LIM);
    scan_addr   = row_base(pixel_row, H_ACTIVE) + ADDR_W'(pixel_column);
    arb_enable  = (state == RUN) && !clear_req;
    probe_grant = probe_req && !active_now && arb_enable && !probe_busy && !probe_ack;
  end

  snake_wr_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_wr_arbiter (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (arb_enable),
    .head_req    (head_req),
    .tail_req    (tail_req),
    .head_grant  (head_grant),
    .tail_grant  (tail_grant),
    .head_ack    (head_ack),
    .tail_ack    (tail_ack)
  );

  // CLEAR/RUN sequencing and the registered write port
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      clear_busy    <= 1'b1;
      ram_wren      <= 1'b0;
      ram_data      <= 1'b0;
      ram_wraddress <= '0;
    end else if (state == CLEAR) begin
      ram_wren      <= 1'b1;
      ram_data      <= 1'b0;
      ram_wraddress <= sweep_ptr;
      clear_busy    <= 1'b1;
      if (sweep_ptr == FB_LAST) begin
        state   <= RUN;
        clr_ptr <= '0;
      end else begin
        clr_ptr <= sweep_ptr + ADDR_W'(1);
      end
    end else if (clear_req) begin
      state      <= CLEAR;
      clr_ptr    <= '0;
      clear_busy <= 1'b1;
      ram_wren   <= 1'b0;
    end else begin
      clear_busy <= 1'b0;
      if (head_grant) begin
        ram_wraddress <= head_addr;
        ram_data      <= head_data;
        ram_wren      <= (head_addr <= FB_LAST);
      end else if (tail_grant) begin
        ram_wraddress <= tail_addr;
        ram_data      <= 1'b0;
        ram_wren      <= (tail_addr <= FB_LAST);
      end else begin
        ram_wren <= 1'b0;
      end
    end
  end

  // read-port mux plus the delay lines that line up pixel and probe results with ram_q
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      ram_rdaddress <= '0;
      active_d1     <= 1'b0;
      active_d2     <= 1'b0;
      pix_data      <= 1'b0;
      probe_ack     <= 1'b0;
      probe_busy    <= 1'b0;
      tag_d1        <= 1'b0;
      tag_d2        <= 1'b0;
      range_d1      <= 1'b0;
      range_d2      <= 1'b0;
      probe_valid   <= 1'b0;
      probe_data    <= 1'b0;
    end else begin
      if (active_now) ram_rdaddress <= scan_addr;
      else if (probe_grant) ram_rdaddress <= probe_addr;
      active_d1   <= active_now;
      active_d2   <= active_d1;
      pix_data    <= active_d2 && !clear_busy && ram_q;
      probe_ack   <= probe_grant;
      tag_d1      <= probe_grant;
      tag_d2      <= tag_d1;
      range_d1    <= probe_addr <= FB_LAST;
      range_d2    <= range_d1;
      probe_valid <= tag_d2;
      probe_data  <= tag_d2 && range_d2 && ram_q;
      if (probe_grant) probe_busy <= 1'b1;
      else if (tag_d2) probe_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snake_ram_scheduler.sv
// Directed bench for snake_ram_scheduler on a 640x16 frame (keeps the clear
// sweep short) with a behavioural 1-cycle-latency snake_ram model. Unwritten
// RAM reads as 1 so the sweep and the zero-forcing paths are observable.
module tb_snake_ram_scheduler;

  localparam int H  = 640;
  localparam int V  = 16;
  localparam int FB = H * V;
  localparam int AW = 19;

  logic          pixel_clock = 1'b0;
  logic          reset = 1'b0;
  logic [9:0]    pixel_row = 10'd500;
  logic [9:0]    pixel_column = 10'd700;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic          head_req = 1'b0;
  logic [AW-1:0] head_addr = '0;
  logic          head_data = 1'b0;
  logic          head_ack;
  logic          tail_req = 1'b0;
  logic [AW-1:0] tail_addr = '0;
  logic          tail_ack;
  logic          probe_req = 1'b0;
  logic [AW-1:0] probe_addr = '0;
  logic          probe_ack;
  logic          probe_valid;
  logic          probe_data;
  logic [AW-1:0] ram_wraddress;
  logic          ram_data;
  logic          ram_wren;
  logic [AW-1:0] ram_rdaddress;
  logic          ram_q = 1'b0;
  logic          pix_data;

  int errors = 0;
  int checks = 0;

  bit mem_inv [0:FB-1];

  snake_ram_scheduler #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .STARVE_MAX (4)
  ) dut (
    .pixel_clock   (pixel_clock),
    .reset         (reset),
    .pixel_row     (pixel_row),
    .pixel_column  (pixel_column),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .head_req      (head_req),
    .head_addr     (head_addr),
    .head_data     (head_data),
    .head_ack      (head_ack),
    .tail_req      (tail_req),
    .tail_addr     (tail_addr),
    .tail_ack      (tail_ack),
    .probe_req     (probe_req),
    .probe_addr    (probe_addr),
    .probe_ack     (probe_ack),
    .probe_valid   (probe_valid),
    .probe_data    (probe_data),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .ram_rdaddress (ram_rdaddress),
    .ram_q         (ram_q),
    .pix_data      (pix_data)
  );

  always #5 pixel_clock = ~pixel_clock;

  // RAM model: old data on same-address read/write, out-of-range reads return 1
  always @(posedge pixel_clock) begin
    if (ram_wren && ram_wraddress < AW'(FB)) mem_inv[ram_wraddress] <= ~ram_data;
    ram_q <= (ram_rdaddress < AW'(FB)) ? ~mem_inv[ram_rdaddress] : 1'b1;
  end

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL reset_clear_busy: got %b want 1", clear_busy); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
    checks++; if (ram_wraddress !== '0) begin errors++; $display("FAIL reset_wraddress: got %0d want 0", ram_wraddress); end
    checks++; if (ram_rdaddress !== '0) begin errors++; $display("FAIL reset_rdaddress: got %0d want 0", ram_rdaddress); end
    checks++; if ({head_ack, tail_ack, probe_ack, probe_valid, pix_data} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b want 00000", {head_ack, tail_ack, probe_ack, probe_valid, pix_data});
    end
  endtask

  task automatic test_sweep();
    int bad;
    int first_bad;
    int acks;
    bad = 0;
    first_bad = -1;
    acks = 0;
    reset = 1'b1;
    head_req = 1'b1;
    head_addr = AW'(300);
    head_data = 1'b1;
    for (int k = 0; k < FB; k++) begin
      tick();
      if (k == 50) head_req = 1'b0;
      if (clear_busy !== 1'b1 || ram_wren !== 1'b1 || ram_wraddress !== AW'(k) || ram_data !== 1'b0) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (head_ack !== 1'b0 || tail_ack !== 1'b0) acks++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_writes: got %0d bad cycles (first at %0d) want 0", bad, first_bad); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL sweep_no_ack: got %0d acks want 0", acks); end
    tick();
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL sweep_done_busy: got %b want 0", clear_busy); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL sweep_done_wren: got %b want 0", ram_wren); end
  endtask

  task automatic test_arbitration();
    head_req = 1'b1; head_addr = AW'(5120); head_data = 1'b1;
    tail_req = 1'b1; tail_addr = AW'(5110);
    tick();
    head_req = 1'b0;
    checks++; if ({head_ack, tail_ack} !== 2'b10) begin errors++; $display("FAIL arb_first_acks: got %b want 10", {head_ack, tail_ack}); end
    checks++; if ({ram_wren, ram_data} !== 2'b11 || ram_wraddress !== AW'(5120)) begin
      errors++; $display("FAIL arb_head_write: got wren=%b data=%b addr=%0d want 1 1 5120", ram_wren, ram_data, ram_wraddress);
    end
    tick();
    tail_req = 1'b0;
    checks++; if ({head_ack, tail_ack} !== 2'b01) begin errors++; $display("FAIL arb_second_acks: got %b want 01", {head_ack, tail_ack}); end
    checks++; if ({ram_wren, ram_data} !== 2'b10 || ram_wraddress !== AW'(5110)) begin
      errors++; $display("FAIL arb_tail_write: got wren=%b data=%b addr=%0d want 1 0 5110", ram_wren, ram_data, ram_wraddress);
    end
    tick();
    checks++; if ({head_ack, tail_ack, ram_wren} !== 3'b000) begin errors++; $display("FAIL arb_idle: got %b want 000", {head_ack, tail_ack, ram_wren}); end
  endtask

  task automatic test_starvation();
    int heads_before;
    int tail_cycle;
    logic head_after;
    logic tail_wr_ok;
    heads_before = 0;
    tail_cycle = 0;
    head_after = 1'b0;
    tail_wr_ok = 1'b0;
    head_req = 1'b1; head_addr = AW'(200); head_data = 1'b0;
    tail_req = 1'b1; tail_addr = AW'(100);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (head_ack) begin
        if (tail_cycle == 0) heads_before++;
        head_addr = head_addr + AW'(1);
      end
      if (tail_ack) begin
        if (tail_cycle == 0) tail_cycle = c;
        tail_wr_ok = ram_wren && ram_wraddress == AW'(100) && !ram_data;
        tail_req = 1'b0;
      end
      if (c == 9) head_after = head_ack;
    end
    head_req = 1'b0;
    tick();
    checks++; if (heads_before !== 4) begin errors++; $display("FAIL starve_head_grants: got %0d want 4", heads_before); end
    checks++; if (tail_cycle !== 8) begin errors++; $display("FAIL starve_tail_cycle: got %0d want 8", tail_cycle); end
    checks++; if (tail_wr_ok !== 1'b1) begin errors++; $display("FAIL starve_tail_write: got %b want 1", tail_wr_ok); end
    checks++; if (head_after !== 1'b1) begin errors++; $display("FAIL starve_head_resume: got %b want 1", head_after); end
  endtask

  task automatic test_probe();
    logic got;
    int waited;
    int col_at;
    got = 1'b0;
    waited = 0;
    col_at = 0;
    pixel_row = 10'd5; pixel_column = 10'd630;
    probe_req = 1'b1; probe_addr = AW'(5120);
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      waited++;
      if (probe_ack) begin
        got = 1'b1;
        col_at = int'(pixel_column);
      end else begin
        pixel_column = pixel_column + 10'd1;
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL probe_ack_timeout: got %b want 1", got); end
    checks++; if (col_at !== 640 || waited !== 11) begin errors++; $display("FAIL probe_blanking: got col=%0d wait=%0d want 640 11", col_at, waited); end
    probe_addr = AW'(5110);
    pixel_row = 10'd500;
    tick();
    checks++; if ({probe_ack, probe_valid} !== 2'b00) begin errors++; $display("FAIL probe_n2: got %b want 00", {probe_ack, probe_valid}); end
    tick();
    checks++; if ({probe_ack, probe_valid, probe_data} !== 3'b011) begin errors++; $display("FAIL probe_n3_data: got %b want 011", {probe_ack, probe_valid, probe_data}); end
    tick();
    probe_req = 1'b0;
    checks++; if ({probe_ack, probe_valid} !== 2'b10) begin errors++; $display("FAIL probe_second_ack: got %b want 10", {probe_ack, probe_valid}); end
    tick();
    tick();
    checks++; if ({probe_valid, probe_data} !== 2'b10) begin errors++; $display("FAIL probe_second_data: got %b want 10", {probe_valid, probe_data}); end
  endtask

  task automatic test_out_of_range();
    head_req = 1'b1; head_addr = AW'(FB); head_data = 1'b1;
    tick();
    head_req = 1'b0;
    checks++; if ({head_ack, ram_wren} !== 2'b10) begin errors++; $display("FAIL oob_head: got ack/wren %b want 10", {head_ack, ram_wren}); end
    tail_req = 1'b1; tail_addr = AW'(FB - 1);
    tick();
    tail_req = 1'b0;
    checks++; if ({tail_ack, ram_wren} !== 2'b11 || ram_wraddress !== AW'(FB - 1)) begin
      errors++; $display("FAIL last_addr_tail: got ack/wren %b addr %0d want 11 %0d", {tail_ack, ram_wren}, ram_wraddress, FB - 1);
    end
    probe_req = 1'b1; probe_addr = AW'(FB);
    tick();
    probe_req = 1'b0;
    checks++; if (probe_ack !== 1'b1) begin errors++; $display("FAIL oob_probe_ack: got %b want 1", probe_ack); end
    tick();
    tick();
    checks++; if ({probe_valid, probe_data} !== 2'b10) begin errors++; $display("FAIL oob_probe_data: got %b want 10", {probe_valid, probe_data}); end
  endtask

  task automatic test_pixel();
    head_req = 1'b1; head_addr = AW'(5 * H + 7); head_data = 1'b1;
    tick();
    head_req = 1'b0;
    tick();
    pixel_row = 10'd5; pixel_column = 10'd7;
    tick();
    pixel_row = 10'd500;
    tick();
    checks++; if (pix_data !== 1'b0) begin errors++; $display("FAIL pix_early: got %b want 0", pix_data); end
    tick();
    checks++; if (pix_data !== 1'b1) begin errors++; $display("FAIL pix_hit: got %b want 1", pix_data); end
    pixel_row = 10'd5; pixel_column = 10'd8;
    tick();
    pixel_row = 10'd500;
    tick();
    tick();
    checks++; if (pix_data !== 1'b0) begin errors++; $display("FAIL pix_neighbor: got %b want 0", pix_data); end
  endtask

  task automatic test_clear_restart();
    pixel_row = 10'd5; pixel_column = 10'd7;
    tick();
    tick();
    tick();
    checks++; if (pix_data !== 1'b1) begin errors++; $display("FAIL restart_pix_before: got %b want 1", pix_data); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++; if ({clear_busy, ram_wren} !== 2'b10) begin errors++; $display("FAIL restart_enter: got busy/wren %b want 10", {clear_busy, ram_wren}); end
    tick();
    checks++; if (pix_data !== 1'b0) begin errors++; $display("FAIL restart_pix_forced: got %b want 0", pix_data); end
    checks++; if ({ram_wren, ram_data} !== 2'b10 || ram_wraddress !== '0) begin
      errors++; $display("FAIL restart_first_write: got wren/data %b addr %0d want 10 0", {ram_wren, ram_data}, ram_wraddress);
    end
    tick();
    checks++; if (ram_wraddress !== AW'(1) || clear_busy !== 1'b1) begin
      errors++; $display("FAIL restart_second_write: got addr %0d busy %b want 1 1", ram_wraddress, clear_busy);
    end
    pixel_row = 10'd500;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_arbitration();
    test_starvation();
    test_probe();
    test_out_of_range();
    test_pixel();
    test_clear_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
